// File: rtl/detector_regs_pkg.sv
// Shared definitions for the detector Avalon register file: register-kind
// encoding, byte-lane mask expansion and kind derivation from the kind masks.
package detector_regs_pkg;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;
    localparam int MAX_REGS   = 64;

    typedef enum logic [1:0] {
        KIND_RW     = 2'd0,
        KIND_PULSE  = 2'd1,
        KIND_IN     = 2'd2,
        KIND_STICKY = 2'd3
    } reg_kind_e;

    // Expand byte enables into a bit mask; callers narrow it to their width.
    function automatic logic [MAX_DATA_W-1:0] be_to_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_BE_W; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    // Sticky only counts on input-sourced registers, pulse only on the others.
    function automatic reg_kind_e reg_kind(input logic [MAX_REGS-1:0] in_m,
                                           input logic [MAX_REGS-1:0] sticky_m,
                                           input logic [MAX_REGS-1:0] pulse_m,
                                           input int                  idx);
        reg_kind_e k;
        k = KIND_RW;
        if (idx >= 0 && idx < MAX_REGS) begin
            if (in_m[idx]) begin
                k = sticky_m[idx] ? KIND_STICKY : KIND_IN;
            end else begin
                k = pulse_m[idx] ? KIND_PULSE : KIND_RW;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/detector_reg_cell.sv
// One register of the detector register file: storage, kind behaviour,
// byte-lane write, registered write strobe and combinational read value.
module detector_reg_cell
    import detector_regs_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter reg_kind_e             KIND       = KIND_RW,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] sig_in,
    output logic [DATA_WIDTH-1:0] sig_out,
    output logic                  wr_strobe,
    output logic [DATA_WIDTH-1:0] rd_val
);

    // Only plain RW registers carry a non-zero reset value.
    localparam logic [DATA_WIDTH-1:0] INIT_VAL = (KIND == KIND_RW) ? RESET_VAL : '0;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  strobe_q, strobe_d;

    // Next-state of the stored value according to the register kind.
    always_comb begin
        logic [DATA_WIDTH-1:0] clr;
        clr      = wr_en ? (wr_data & wr_mask) : '0;
        data_d   = data_q;
        strobe_d = wr_en;
        case (KIND)
            KIND_RW: begin
                if (wr_en) begin
                    data_d = (data_q & ~wr_mask) | (wr_data & wr_mask);
                end
            end
            KIND_PULSE: begin
                data_d = clr;
            end
            KIND_STICKY: begin
                // New input events are ORed in after the clear so none is lost.
                data_d = (data_q & ~clr) | sig_in;
            end
            default: begin
                data_d = '0;
            end
        endcase
    end

    // Register storage and strobe with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= INIT_VAL;
            strobe_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    // Control output and read value per kind.
    always_comb begin
        sig_out = '0;
        rd_val  = '0;
        case (KIND)
            KIND_RW: begin
                sig_out = data_q;
                rd_val  = data_q;
            end
            KIND_PULSE: begin
                sig_out = data_q;
            end
            KIND_STICKY: begin
                rd_val = data_q;
            end
            default: begin
                rd_val = sig_in;
            end
        endcase
    end

    assign wr_strobe = strobe_q;

endmodule

// File: rtl/detector_avalon_regfile.sv
// Avalon-MM slave register file for the video detector driver.
// Address decode, one-cycle read pipeline and optional interrupt.
// Optional macro DETECTOR_REGS_IRQ_EN adds an irq-enable register at address
// REGS_NUM and the irq output.
module detector_avalon_regfile
    import detector_regs_pkg::*;
#(
    parameter int                               ADDR_WIDTH       = 4,
    parameter int                               DATA_WIDTH       = 32,
    parameter int                               REGS_NUM         = 10,
    parameter logic [MAX_REGS-1:0]              REGS_IN_MASK     = '0,
    parameter logic [MAX_REGS-1:0]              REGS_STICKY_MASK = '0,
    parameter logic [MAX_REGS-1:0]              REGS_PULSE_MASK  = '0,
    parameter logic [REGS_NUM*DATA_WIDTH-1:0]   REGS_RESET       = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            av_address,
    input  logic                             av_read,
    input  logic                             av_write,
    input  logic [DATA_WIDTH/8-1:0]          av_byteenable,
    input  logic [DATA_WIDTH-1:0]            av_writedata,
    output logic [DATA_WIDTH-1:0]            av_readdata,
    output logic                             av_readdatavalid,
    input  logic [REGS_NUM*DATA_WIDTH-1:0]   register_signal_in,
    output logic [REGS_NUM*DATA_WIDTH-1:0]   register_signal_out,
    output logic [REGS_NUM-1:0]              register_write_strobe
`ifdef DETECTOR_REGS_IRQ_EN
    ,
    output logic                             irq
`endif
);

    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] rd_vals [REGS_NUM];
    logic [DATA_WIDTH-1:0] rd_sel;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    assign lane_mask = DATA_WIDTH'(be_to_mask(MAX_BE_W'(av_byteenable)));

    for (genvar i = 0; i < REGS_NUM; i++) begin : g_reg
        localparam reg_kind_e K = reg_kind(REGS_IN_MASK, REGS_STICKY_MASK, REGS_PULSE_MASK, i);
        logic wr_hit;
        assign wr_hit = av_write && (int'(av_address) == i);

        detector_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .KIND       (K),
            .RESET_VAL  (REGS_RESET[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_hit),
            .wr_data   (av_writedata),
            .wr_mask   (lane_mask),
            .sig_in    (register_signal_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .sig_out   (register_signal_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .wr_strobe (register_write_strobe[i]),
            .rd_val    (rd_vals[i])
        );
    end

`ifdef DETECTOR_REGS_IRQ_EN
    logic [DATA_WIDTH-1:0] irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;

    // Irq-enable register update and interrupt from enabled sticky bits.
    always_comb begin
        logic [DATA_WIDTH-1:0] sticky_any;
        irq_en_d = irq_en_q;
        if (av_write && (int'(av_address) == REGS_NUM)) begin
            irq_en_d = (irq_en_q & ~lane_mask) | (av_writedata & lane_mask);
        end
        sticky_any = '0;
        for (int i = 0; i < REGS_NUM; i++) begin
            if (reg_kind(REGS_IN_MASK, REGS_STICKY_MASK, REGS_PULSE_MASK, i) == KIND_STICKY) begin
                sticky_any = sticky_any | rd_vals[i];
            end
        end
        irq_d = |(sticky_any & irq_en_q);
    end

    // Irq-enable and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // Read mux over current state: a same-cycle write is not yet visible.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < REGS_NUM; i++) begin
            if (int'(av_address) == i) begin
                rd_sel = rd_vals[i];
            end
        end
`ifdef DETECTOR_REGS_IRQ_EN
        if (int'(av_address) == REGS_NUM) begin
            rd_sel = irq_en_q;
        end
`endif
        rdata_d  = av_read ? rd_sel : rdata_q;
        rvalid_d = av_read;
    end

    // Read response stage; readdata holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign av_readdata      = rdata_q;
    assign av_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_detector_avalon_regfile.sv
// Self-checking bench for detector_avalon_regfile: directed table, hand
// sequences for irq and reset-mid-read, then randomized traffic against a
// behavioural model. Irq checks are active when DETECTOR_REGS_IRQ_EN is defined.
module tb_detector_avalon_regfile;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 10;
    localparam logic [63:0] IN_M = 64'h18;   // regs 3 (sticky) and 4 (live input)
    localparam logic [63:0] ST_M = 64'h08;
    localparam logic [63:0] PU_M = 64'h04;   // reg 2 pulse
    localparam logic [N*DW-1:0] RST = {32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D,
                                       32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     av_address;
    logic              av_read, av_write;
    logic [DW/8-1:0]   av_byteenable;
    logic [DW-1:0]     av_writedata;
    logic [DW-1:0]     av_readdata;
    logic              av_readdatavalid;
    logic [N*DW-1:0]   sig_in;
    logic [N*DW-1:0]   sig_out;
    logic [N-1:0]      strobe;
`ifdef DETECTOR_REGS_IRQ_EN
    logic              irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    detector_avalon_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGS_NUM(N),
        .REGS_IN_MASK(IN_M), .REGS_STICKY_MASK(ST_M), .REGS_PULSE_MASK(PU_M),
        .REGS_RESET(RST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_byteenable(av_byteenable), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
        .register_signal_in(sig_in), .register_signal_out(sig_out),
        .register_write_strobe(strobe)
`ifdef DETECTOR_REGS_IRQ_EN
        , .irq(irq)
`endif
    );

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_rw [N];
    logic [DW-1:0] m_sticky [N];
    logic [DW-1:0] m_pulse [N];
    logic [DW-1:0] m_en;
    logic          m_irq;
    logic [DW-1:0] exp_rdata;
    logic          exp_valid;
    logic [N-1:0]  exp_strobe;

    function automatic bit is_rw(int i);     return !IN_M[i] && !PU_M[i]; endfunction
    function automatic bit is_pulse(int i);  return !IN_M[i] &&  PU_M[i]; endfunction
    function automatic bit is_sticky(int i); return  IN_M[i] &&  ST_M[i]; endfunction

    function automatic logic [DW-1:0] lanes(logic [DW/8-1:0] be);
        logic [DW-1:0] m = '0;
        for (int b = 0; b < DW/8; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_rw[i]     = RST[i*DW +: DW];
            m_sticky[i] = '0;
            m_pulse[i]  = '0;
        end
        m_en = '0; m_irq = 1'b0;
        exp_rdata = '0; exp_valid = 1'b0; exp_strobe = '0;
    endtask

    function automatic logic [DW-1:0] model_read(int a, logic [N*DW-1:0] si);
        logic [DW-1:0] v = '0;
        if (a < N) begin
            if (is_rw(a))          v = m_rw[a];
            else if (is_sticky(a)) v = m_sticky[a];
            else if (IN_M[a])      v = si[a*DW +: DW];
        end
`ifdef DETECTOR_REGS_IRQ_EN
        else if (a == N) v = m_en;
`endif
        return v;
    endfunction

    // One clock edge of the register file's visible behaviour.
    task automatic model_step(bit rd, bit wr, int a, logic [DW/8-1:0] be,
                              logic [DW-1:0] wd, logic [N*DW-1:0] si);
        logic [DW-1:0] m = lanes(be);
        logic [DW-1:0] any = '0;
        exp_valid = rd;
        if (rd) exp_rdata = model_read(a, si);
        for (int i = 0; i < N; i++) if (is_sticky(i)) any |= m_sticky[i];
        m_irq = |(any & m_en);
        exp_strobe = '0;
        for (int i = 0; i < N; i++) m_pulse[i] = '0;
        if (wr && a < N) begin
            exp_strobe[a] = 1'b1;
            if (is_rw(a))    m_rw[a] = (m_rw[a] & ~m) | (wd & m);
            if (is_pulse(a)) m_pulse[a] = wd & m;
        end
`ifdef DETECTOR_REGS_IRQ_EN
        if (wr && a == N) m_en = (m_en & ~m) | (wd & m);
`endif
        for (int i = 0; i < N; i++) begin
            if (is_sticky(i)) begin
                logic [DW-1:0] clr = (wr && a == i) ? (wd & m) : '0;
                m_sticky[i] = (m_sticky[i] & ~clr) | si[i*DW +: DW];
            end
        end
    endtask

    function automatic logic [N*DW-1:0] model_out();
        logic [N*DW-1:0] o = '0;
        for (int i = 0; i < N; i++) begin
            if (is_rw(i))    o[i*DW +: DW] = m_rw[i];
            if (is_pulse(i)) o[i*DW +: DW] = m_pulse[i];
        end
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string name, logic [N*DW-1:0] act, logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("rvalid", av_readdatavalid, exp_valid);
        chk("rdata", av_readdata, exp_rdata);
        chk("sig_out", sig_out, model_out());
        chk("strobe", strobe, exp_strobe);
`ifdef DETECTOR_REGS_IRQ_EN
        chk("irq", irq, m_irq);
`endif
    endtask

    task automatic cycle(bit rd, bit wr, int a, logic [DW/8-1:0] be,
                         logic [DW-1:0] wd, logic [N*DW-1:0] si);
        av_read = rd; av_write = wr; av_address = AW'(a);
        av_byteenable = be; av_writedata = wd; sig_in = si;
        @(posedge clk);
        model_step(rd, wr, a, be, wd, si);
        #1;
        check_all();
    endtask

    typedef struct {
        bit            rd;
        bit            wr;
        int            addr;
        logic [3:0]    be;
        logic [DW-1:0] wd;
        logic [DW-1:0] in3;
        logic [DW-1:0] in4;
        bit            exp_v;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t tbl [21];

    initial begin
        logic [N*DW-1:0] si;

        tbl[0]  = '{1, 0, 0,  4'hF, 32'h0,        0, 0,            1, 32'h12345678};
        tbl[1]  = '{0, 1, 1,  4'h5, 32'hAABBCCDD, 0, 0,            0, 32'h12345678};
        tbl[2]  = '{1, 0, 1,  4'hF, 32'h0,        0, 0,            1, 32'h00BB00DD};
        tbl[3]  = '{0, 1, 2,  4'hF, 32'h1,        0, 0,            0, 32'h00BB00DD};
        tbl[4]  = '{0, 0, 0,  4'hF, 32'h0,        0, 0,            0, 32'h00BB00DD};
        tbl[5]  = '{1, 0, 2,  4'hF, 32'h0,        0, 0,            1, 32'h0};
        tbl[6]  = '{0, 0, 0,  4'hF, 32'h0,        5, 0,            0, 32'h0};
        tbl[7]  = '{1, 0, 3,  4'hF, 32'h0,        0, 0,            1, 32'h5};
        tbl[8]  = '{0, 1, 3,  4'hF, 32'h1,        0, 0,            0, 32'h5};
        tbl[9]  = '{1, 0, 3,  4'hF, 32'h0,        0, 0,            1, 32'h4};
        tbl[10] = '{0, 1, 3,  4'hF, 32'h2,        2, 0,            0, 32'h4};
        tbl[11] = '{1, 0, 3,  4'hF, 32'h0,        0, 0,            1, 32'h6};
        tbl[12] = '{1, 0, 0,  4'hF, 32'h0,        0, 0,            1, 32'h12345678};
        tbl[13] = '{1, 0, 1,  4'hF, 32'h0,        0, 0,            1, 32'h00BB00DD};
        tbl[14] = '{1, 0, 15, 4'hF, 32'h0,        0, 0,            1, 32'h0};
        tbl[15] = '{1, 1, 1,  4'hF, 32'h11111111, 0, 0,            1, 32'h00BB00DD};
        tbl[16] = '{1, 0, 1,  4'hF, 32'h0,        0, 0,            1, 32'h11111111};
        tbl[17] = '{1, 0, 4,  4'hF, 32'h0,        0, 32'hDEADBEEF, 1, 32'hDEADBEEF};
        tbl[18] = '{0, 1, 12, 4'hF, 32'h55555555, 0, 0,            0, 32'hDEADBEEF};
        tbl[19] = '{1, 0, 10, 4'hF, 32'h0,        0, 0,            1, 32'h0};
        tbl[20] = '{1, 0, 5,  4'hF, 32'h0,        0, 0,            1, 32'hCAFEF00D};

        rst_n = 1'b0; av_read = 0; av_write = 0; av_address = '0;
        av_byteenable = '0; av_writedata = '0; sig_in = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;

        // Directed table
        foreach (tbl[k]) begin
            si = '0;
            si[3*DW +: DW] = tbl[k].in3;
            si[4*DW +: DW] = tbl[k].in4;
            cycle(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].be, tbl[k].wd, si);
            chk($sformatf("tbl%0d_valid", k), av_readdatavalid, tbl[k].exp_v);
            chk($sformatf("tbl%0d_rdata", k), av_readdata, tbl[k].exp_d);
        end

        // Interrupt sequence: clear sticky, enable bit 2, raise and clear it
        si = '0;
        cycle(0, 1, 3, 4'hF, 32'hFFFFFFFF, si);
        cycle(0, 1, N, 4'hF, 32'h4, si);
        si[3*DW +: DW] = 32'h4;
        cycle(0, 0, 0, 4'h0, 32'h0, si);
        si = '0;
`ifdef DETECTOR_REGS_IRQ_EN
        chk("irq_before_rise", irq, 1'b0);
`endif
        cycle(0, 0, 0, 4'h0, 32'h0, si);
`ifdef DETECTOR_REGS_IRQ_EN
        chk("irq_rise", irq, 1'b1);
`endif
        cycle(1, 1, 3, 4'hF, 32'h4, si);
        chk("sticky_pre_clear_read", av_readdata, 32'h4);
        cycle(0, 0, 0, 4'h0, 32'h0, si);
`ifdef DETECTOR_REGS_IRQ_EN
        chk("irq_fall", irq, 1'b0);
`endif

        // Reset asserted while a read is pending
        av_read = 1'b1; av_write = 1'b0; av_address = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_read_valid", av_readdatavalid, 1'b0);
        chk("rst_mid_read_data", av_readdata, 32'h0);
`ifdef DETECTOR_REGS_IRQ_EN
        chk("rst_mid_read_irq", irq, 1'b0);
`endif
        @(posedge clk);
        #1;
        av_read = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, 4'h0, 32'h0, '0);
        chk("post_reset_no_valid", av_readdatavalid, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [N*DW-1:0] r;
            for (int i = 0; i < N; i++) r[i*DW +: DW] = $urandom & $urandom & $urandom;
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), 4'($urandom), $urandom, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
